// File: rtl/hyperspectral_pkg.sv
// Shared types and fixed-point helpers for the hyperspectral LCMV pipeline stages.
package hyperspectral_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_LOAD_W = 2'd0;
   localparam state_t S_ACCUM  = 2'd1;
   localparam state_t S_EMIT   = 2'd2;
   localparam state_t S_DONE   = 2'd3;

   localparam int SAT_ACC_MAX = 128;
   localparam int SAT_OUT_MAX = 64;

   // acc carries an acc_w-bit two's-complement value zero-extended into 128 bits;
   // result is the Q-format value shifted down and clamped to a signed width-bit range.
   function automatic logic [SAT_OUT_MAX-1:0] sat_shift(
      input logic [SAT_ACC_MAX-1:0] acc,
      input int                     acc_w,
      input int                     width,
      input int                     frac_bits
   );
      logic signed [SAT_ACC_MAX-1:0] ext;
      logic signed [SAT_ACC_MAX-1:0] sh;
      logic signed [SAT_ACC_MAX-1:0] hi;
      logic signed [SAT_ACC_MAX-1:0] lo;
      ext = $signed(acc << (SAT_ACC_MAX - acc_w)) >>> (SAT_ACC_MAX - acc_w);
      sh  = ext >>> frac_bits;
      hi  = (128'sd1 <<< (width - 1)) - 128'sd1;
      lo  = -(128'sd1 <<< (width - 1));
      if (sh > hi)
         sat_shift = hi[SAT_OUT_MAX-1:0];
      else if (sh < lo)
         sat_shift = lo[SAT_OUT_MAX-1:0];
      else
         sat_shift = sh[SAT_OUT_MAX-1:0];
   endfunction

endpackage

// File: rtl/fixed_mac_lane.sv
// One signed multiply-accumulate lane: clr loads the product, otherwise it is added.
module fixed_mac_lane #(
   parameter int WIDTH = 32,
   parameter int ACC_W = 68
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] w,
   input  logic [WIDTH-1:0] x,
   output logic [ACC_W-1:0] acc
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   prod_ext;

   assign prod     = $signed(w) * $signed(x);
   assign prod_ext = ACC_W'(prod);

   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (en)
         acc <= clr ? prod_ext : acc + prod_ext;
   end

endmodule

// File: rtl/weighting_matrix_apply_axis.sv
// Loads the weighting matrix W from a stream, then emits y = W*x per pixel of the
// incoming hyperspectral image on an AXI-Stream master.
module weighting_matrix_apply_axis
   import hyperspectral_pkg::*;
#(
   parameter int WIDTH               = 32,
   parameter int FRAC_BITS           = 16,
   parameter int NUM_PIXELS          = 50,
   parameter int NUM_CHANNELS        = 11,
   parameter int NUM_OUTPUT_CHANNELS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] axis_w_data,
   input  logic             axis_w_valid,
   input  logic             axis_w_last,
   output logic             axis_w_ready,
   input  logic [WIDTH-1:0] axis_p_data,
   input  logic             axis_p_valid,
   output logic             axis_p_ready,
   output logic [WIDTH-1:0] axis_y_data,
   output logic             axis_y_valid,
   output logic             axis_y_last,
   input  logic             axis_y_ready,
   output logic             finished,
   output logic             error
);

   localparam int ACC_W = 2*WIDTH + $clog2(NUM_CHANNELS);
   localparam int CH_W  = (NUM_CHANNELS > 1)        ? $clog2(NUM_CHANNELS)        : 1;
   localparam int OC_W  = (NUM_OUTPUT_CHANNELS > 1) ? $clog2(NUM_OUTPUT_CHANNELS) : 1;
   localparam int PX_W  = (NUM_PIXELS > 1)          ? $clog2(NUM_PIXELS)          : 1;

   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CHANNELS - 1);
   localparam logic [OC_W-1:0] LAST_OC  = OC_W'(NUM_OUTPUT_CHANNELS - 1);
   localparam logic [PX_W-1:0] LAST_PIX = PX_W'(NUM_PIXELS - 1);

   state_t state;

   logic [NUM_OUTPUT_CHANNELS-1:0][NUM_CHANNELS-1:0][WIDTH-1:0] w_mem;
   logic [NUM_OUTPUT_CHANNELS-1:0][ACC_W-1:0]                   acc;

   logic [OC_W-1:0] w_row;
   logic [CH_W-1:0] w_col;
   logic [CH_W-1:0] ch;
   logic [OC_W-1:0] k;
   logic [PX_W-1:0] pix;
   logic            error_q;

   logic w_hs, p_hs, y_hs, w_final;

   // Readies come from state alone so upstream never sees a valid->ready path.
   assign axis_w_ready = (state == S_LOAD_W);
   assign axis_p_ready = (state == S_ACCUM);
   assign axis_y_valid = (state == S_EMIT);
   assign axis_y_last  = axis_y_valid && (k == LAST_OC) && (pix == LAST_PIX);
   assign finished     = (state == S_DONE);
   assign error        = error_q;

   assign w_hs    = axis_w_valid && axis_w_ready;
   assign p_hs    = axis_p_valid && axis_p_ready;
   assign y_hs    = axis_y_valid && axis_y_ready;
   assign w_final = (w_row == LAST_OC) && (w_col == LAST_CH);

   // Output is a pure function of registers, so it holds while stalled.
   assign axis_y_data = WIDTH'(sat_shift(SAT_ACC_MAX'(acc[k]), ACC_W, WIDTH, FRAC_BITS));

   for (genvar g = 0; g < NUM_OUTPUT_CHANNELS; g++) begin : g_lane
      fixed_mac_lane #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .en  (p_hs),
         .clr (ch == '0),
         .w   (w_mem[g][ch]),
         .x   (axis_p_data),
         .acc (acc[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_LOAD_W;
         w_mem   <= '0;
         w_row   <= '0;
         w_col   <= '0;
         ch      <= '0;
         k       <= '0;
         pix     <= '0;
         error_q <= 1'b0;
      end else begin
         case (state)
            S_LOAD_W: if (w_hs) begin
               w_mem[w_row][w_col] <= axis_w_data;
               // Framing is judged by word count; a bad last flag is flagged, not obeyed.
               if (axis_w_last != w_final)
                  error_q <= 1'b1;
               if (w_final) begin
                  w_row <= '0;
                  w_col <= '0;
                  state <= S_ACCUM;
               end else if (w_col == LAST_CH) begin
                  w_col <= '0;
                  w_row <= w_row + 1'b1;
               end else begin
                  w_col <= w_col + 1'b1;
               end
            end
            S_ACCUM: if (p_hs) begin
               if (ch == LAST_CH) begin
                  ch    <= '0;
                  k     <= '0;
                  state <= S_EMIT;
               end else begin
                  ch <= ch + 1'b1;
               end
            end
            S_EMIT: if (y_hs) begin
               if (k == LAST_OC) begin
                  k <= '0;
                  if (pix == LAST_PIX) begin
                     state <= S_DONE;
                  end else begin
                     pix   <= pix + 1'b1;
                     state <= S_ACCUM;
                  end
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_weighting_matrix_apply_axis.sv
// Scoreboard bench: driver pushes reference y words, a negedge monitor pops and compares.
module tb_weighting_matrix_apply_axis;

   localparam int WD = 32;
   localparam int FB = 16;
   localparam int NP = 2;
   localparam int NC = 3;
   localparam int NO = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [WD-1:0] axis_w_data;
   logic          axis_w_valid;
   logic          axis_w_last;
   logic          axis_w_ready;
   logic [WD-1:0] axis_p_data;
   logic          axis_p_valid;
   logic          axis_p_ready;
   logic [WD-1:0] axis_y_data;
   logic          axis_y_valid;
   logic          axis_y_last;
   logic          axis_y_ready;
   logic          finished;
   logic          error;

   weighting_matrix_apply_axis #(
      .WIDTH               (WD),
      .FRAC_BITS           (FB),
      .NUM_PIXELS          (NP),
      .NUM_CHANNELS        (NC),
      .NUM_OUTPUT_CHANNELS (NO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .axis_w_data  (axis_w_data),
      .axis_w_valid (axis_w_valid),
      .axis_w_last  (axis_w_last),
      .axis_w_ready (axis_w_ready),
      .axis_p_data  (axis_p_data),
      .axis_p_valid (axis_p_valid),
      .axis_p_ready (axis_p_ready),
      .axis_y_data  (axis_y_data),
      .axis_y_valid (axis_y_valid),
      .axis_y_last  (axis_y_last),
      .axis_y_ready (axis_y_ready),
      .finished     (finished),
      .error        (error)
   );

   always #5 clk = ~clk;

   logic [31:0] wm [NO][NC];
   logic [31:0] xm [NP][NC];
   logic [32:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;
   int rdy_mode = 0;
   int gap_max = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // y = sat((sum_c W[k][c]*x[c]) >>> FB), done in wide integer arithmetic.
   function automatic logic [31:0] ref_y(input int p, input int k);
      logic signed [127:0] s, a, b;
      s = '0;
      for (int c = 0; c < NC; c++) begin
         a = $signed(wm[k][c]);
         b = $signed(xm[p][c]);
         s = s + a * b;
      end
      s = s >>> FB;
      if (s > 128'sh7fff_ffff) return 32'h7fff_ffff;
      if (s < -128'sh8000_0000) return 32'h8000_0000;
      return s[31:0];
   endfunction

   // ---------------- monitor ----------------
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(axis_y_valid), 32'd1);
            chk("stall_data", axis_y_data, prev_data);
            chk("stall_last", 32'(axis_y_last), 32'(prev_last));
         end
         if (axis_y_valid && axis_p_ready)
            chk("p_ready_in_emit", 32'(axis_p_ready), 32'd0);
         if (axis_y_valid && axis_y_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_y", 32'(exp_q.size()), 32'd1);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               chk("y_data", axis_y_data, e[31:0]);
               chk("y_last", 32'(axis_y_last), 32'(e[32]));
            end
         end
         prev_stall <= axis_y_valid && !axis_y_ready;
         prev_data  <= axis_y_data;
         prev_last  <= axis_y_last;
      end
   end

   // ---------------- y_ready driver ----------------
   initial begin
      int bp = 0;
      axis_y_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: begin
               axis_y_ready = (bp % 4 == 0) || (bp % 4 == 3);
               bp++;
            end
            2: axis_y_ready = ($urandom_range(9, 0) < 7);
            default: axis_y_ready = 1'b1;
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic gap();
      repeat ($urandom_range(gap_max, 0)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_w(input logic [31:0] d, input logic l);
      int t;
      logic got;
      gap();
      axis_w_data  = d;
      axis_w_last  = l;
      axis_w_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         got = axis_w_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!got && t < 200);
      if (!got) chk("w_handshake_timeout", 32'(got), 32'd1);
      axis_w_valid = 1'b0;
      axis_w_last  = 1'b0;
   endtask

   task automatic send_p(input logic [31:0] d);
      int t;
      logic got;
      gap();
      axis_p_data  = d;
      axis_p_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         got = axis_p_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!got && t < 200);
      if (!got) chk("p_handshake_timeout", 32'(got), 32'd1);
      axis_p_valid = 1'b0;
   endtask

   // bad: 0 clean, 1 last asserted on word 4, 2 last dropped on the final word
   task automatic load_w(input int bad);
      for (int r = 0; r < NO; r++)
         for (int c = 0; c < NC; c++) begin
            int idx;
            logic l;
            idx = r * NC + c;
            l = (idx == NO * NC - 1);
            if (bad == 1 && idx == 3) l = 1'b1;
            if (bad == 2 && idx == NO * NC - 1) l = 1'b0;
            send_w(wm[r][c], l);
         end
   endtask

   task automatic send_image();
      for (int p = 0; p < NP; p++) begin
         for (int k = 0; k < NO; k++)
            exp_q.push_back({(p == NP - 1) && (k == NO - 1), ref_y(p, k)});
         for (int c = 0; c < NC; c++)
            send_p(xm[p][c]);
      end
   endtask

   task automatic wait_done(input logic exp_err);
      int t;
      t = 0;
      while (!finished && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("finished", 32'(finished), 32'd1);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("error_flag", 32'(error), 32'(exp_err));
      chk("done_y_valid", 32'(axis_y_valid), 32'd0);
      chk("done_w_ready", 32'(axis_w_ready), 32'd0);
      chk("done_p_ready", 32'(axis_p_ready), 32'd0);
   endtask

   task automatic do_reset();
      axis_w_valid = 1'b0;
      axis_w_last  = 1'b0;
      axis_p_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      chk("rst_w_ready", 32'(axis_w_ready), 32'd1);
      chk("rst_p_ready", 32'(axis_p_ready), 32'd0);
      chk("rst_y_valid", 32'(axis_y_valid), 32'd0);
      chk("rst_y_last", 32'(axis_y_last), 32'd0);
      chk("rst_y_data", axis_y_data, 32'd0);
      chk("rst_finished", 32'(finished), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      rst = 1'b0;
   endtask

   task automatic set_basic();
      wm[0][0] = 32'h0001_0000; wm[0][1] = 32'h0; wm[0][2] = 32'h0;
      wm[1][0] = 32'h0;         wm[1][1] = 32'h0001_0000; wm[1][2] = 32'h0;
      xm[0][0] = 32'h0002_0000; xm[0][1] = 32'h0003_0000; xm[0][2] = 32'h0004_0000;
      xm[1][0] = 32'hFFFF_0000; xm[1][1] = 32'h0005_0000; xm[1][2] = 32'h0007_0000;
   endtask

   task automatic set_const(input logic [31:0] wv, input logic [31:0] xv);
      for (int r = 0; r < NO; r++)
         for (int c = 0; c < NC; c++) wm[r][c] = wv;
      for (int p = 0; p < NP; p++)
         for (int c = 0; c < NC; c++) xm[p][c] = xv;
   endtask

   function automatic logic [31:0] rnd();
      logic [31:0] v;
      if ($urandom_range(3, 0) == 0) begin
         v = $urandom;
      end else begin
         v = $urandom_range(32'h000F_FFFF, 0);
         v = v - 32'h0008_0000;
      end
      return v;
   endfunction

   task automatic set_random();
      for (int r = 0; r < NO; r++)
         for (int c = 0; c < NC; c++) wm[r][c] = rnd();
      for (int p = 0; p < NP; p++)
         for (int c = 0; c < NC; c++) xm[p][c] = rnd();
   endtask

   initial begin
      axis_w_data  = '0;
      axis_w_valid = 1'b0;
      axis_w_last  = 1'b0;
      axis_p_data  = '0;
      axis_p_valid = 1'b0;
      rst          = 1'b1;
      @(posedge clk);
      #1;

      // basic path
      do_reset();
      set_basic();
      load_w(0);
      send_image();
      wait_done(1'b0);

      // backpressure 1-0-0-1
      rdy_mode = 1;
      do_reset();
      set_basic();
      load_w(0);
      send_image();
      wait_done(1'b0);
      rdy_mode = 0;

      // saturation both ways
      do_reset();
      set_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      load_w(0);
      send_image();
      wait_done(1'b0);
      do_reset();
      set_const(32'h8000_0000, 32'h7FFF_FFFF);
      load_w(0);
      send_image();
      wait_done(1'b0);

      // framing errors: early last, then missing last
      do_reset();
      set_random();
      load_w(1);
      send_image();
      wait_done(1'b1);
      do_reset();
      set_random();
      load_w(2);
      send_image();
      wait_done(1'b1);

      // reset after two pixel samples, then full rerun
      do_reset();
      set_const(32'h0003_0000, 32'h0001_0000);
      load_w(0);
      send_p(32'h0001_0000);
      send_p(32'h0002_0000);
      do_reset();
      set_basic();
      load_w(0);
      send_image();
      wait_done(1'b0);

      // randomized data with valid/ready gaps
      rdy_mode = 2;
      gap_max  = 2;
      for (int it = 0; it < 30; it++) begin
         do_reset();
         set_random();
         load_w(0);
         send_image();
         wait_done(1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/weighting_matrix_apply_axis.md
Name: weighting_matrix_apply_axis

Overview:
Downstream consumer of the weighting-matrix stream. Captures the NUM_OUTPUT_CHANNELS x NUM_CHANNELS matrix W produced by weighting_matrix_tc_axi_wrapper into internal registers. It then streams the hyperspectral image and computes y = W·x per pixel, emitting the reduced-channel output image on an AXI-Stream master. It is the final classification stage of the LCMV pipeline and is checked against golden output ROMs through axis_comparator.

Parameters:
WIDTH, 32, sample/coefficient width; signed two's-complement fixed point
FRAC_BITS, 16, fractional bits of W, x and y (same Q format for all three)
NUM_PIXELS, 50, pixels per image
NUM_CHANNELS, 11, input spectral channels per pixel
NUM_OUTPUT_CHANNELS, 3, rows of W / output channels per pixel

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
axis_w_data  in  WIDTH  W coefficient, row-major (row = output channel)
axis_w_valid  in  1  W word valid
axis_w_last  in  1  marks final W word
axis_w_ready  out  1  W word accepted when valid&ready
axis_p_data  in  WIDTH  pixel sample, pixel-major, channel 0 first
axis_p_valid  in  1  pixel sample valid
axis_p_ready  out  1  pixel sample accepted when valid&ready
axis_y_data  out  WIDTH  output sample, pixel-major, output channel 0 first
axis_y_valid  out  1  output sample valid
axis_y_last  out  1  final output sample of image
axis_y_ready  in  1  downstream accepts
finished  out  1  image complete; sticky until rst
error  out  1  W framing error; sticky until rst

Behaviour:
- Clock domain: single clock clk; rst is synchronous, active-high.
- Reset: state S_LOAD_W, all counters 0, accumulators 0.
- Output values on reset: axis_w_ready=1, axis_p_ready=0, axis_y_valid=0, axis_y_last=0, axis_y_data=0, finished=0, error=0.
- Ready signals are decoded from registered state only; they never depend combinationally on the valid inputs.
- Every handshake is valid&ready on a rising edge.
- States:
  - S_LOAD_W: axis_w_ready=1. Each W handshake writes W[row][col] and advances col, then row. After word NUM_OUTPUT_CHANNELS*NUM_CHANNELS is accepted, go to S_ACCUM.
  - S_ACCUM: axis_p_ready=1. Each handshake at channel c updates every lane k. At c=0: acc[k] = W[k][0]*x (accumulator cleared, not added). At c>0: acc[k] += W[k][c]*x. On the c=NUM_CHANNELS-1 handshake, go to S_EMIT.
  - S_EMIT: axis_p_ready=0, axis_y_valid=1. axis_y_data = sat(acc[k] >>> FRAC_BITS), where k is the output index. Each y handshake advances k. After k=NUM_OUTPUT_CHANNELS-1: if this is the last pixel, go to S_DONE; otherwise go to S_ACCUM.
  - S_DONE: all readies 0, axis_y_valid=0, finished=1. Holds until rst.
- W framing is counter-based and errors do not stall the block:
  - axis_w_last=1 on any word other than the final one sets error.
  - axis_w_last=0 on the final word sets error.
- Arithmetic:
  - Product is 2*WIDTH bits signed.
  - Accumulator is 2*WIDTH+$clog2(NUM_CHANNELS) bits signed.
  - Shift is arithmetic right shift by FRAC_BITS (truncation toward -inf).
  - Saturation clamps to 0x7FFF_FFFF / 0x8000_0000 for WIDTH=32.
- Latency: the last-channel handshake at edge t gives axis_y_valid=1 after edge t, i.e. one cycle.
- Backpressure: while axis_y_valid=1 and axis_y_ready=0, axis_y_data and axis_y_last hold stable.
- axis_y_last=1 only on output NUM_OUTPUT_CHANNELS-1 of pixel NUM_PIXELS-1.
- Reset mid-operation discards W, accumulators and counters; the block restarts in S_LOAD_W.

Decomposition:
- Shared package hyperspectral_pkg holds:
  - the state typedef (S_LOAD_W, S_ACCUM, S_EMIT, S_DONE);
  - a sat_shift function (accumulator width, WIDTH, FRAC_BITS) reused by other fixed-point stages.
- One sub-module, fixed_mac_lane, holds one accumulator with clear/accumulate enables. The top instantiates NUM_OUTPUT_CHANNELS lanes in a generate loop.

Test Plan:
All directed tests use NUM_CHANNELS=3, NUM_OUTPUT_CHANNELS=2, NUM_PIXELS=2, FRAC_BITS=16, unless a test states otherwise.
1. Basic path: W={0x10000,0,0; 0,0x10000,0}, pixels (0x20000,0x30000,0x40000), (0xFFFF0000,0x50000,0x70000) -> y=0x20000,0x30000,0xFFFF0000,0x50000; last on 4th word only; then finished=1.
2. Backpressure: same as test 1 with axis_y_ready toggled 1-0-0-1 -> data/last stable while stalled; axis_p_ready=0 throughout S_EMIT; sequence identical to test 1.
3. Saturation: W all 0x7FFFFFFF and x all 0x7FFFFFFF -> y=0x7FFFFFFF; W all 0x80000000 and x all 0x7FFFFFFF -> y=0x80000000.
4. Framing errors:
   - axis_w_last=1 on W word 4 of 6 -> error=1 sticky; load still completes after 6 words.
   - axis_w_last=0 on word 6 -> error=1.
5. Reset mid-operation: rst for one cycle after 2 pixel samples accepted -> all outputs at reset values; reload W and pixels -> results identical to test 1.
6. Golden regression: defaults (50/11/3) with test_w_1 and test_x_1 ROMs, and random valid/ready gaps -> axis_comparator result reports pass; 150 outputs, finished=1.
